// File: rtl/timer_ctrl.sv
// Sequencing controller for the general-purpose up counter: loads the trigger, gates the enable,
// re-arms after each match and emits tick/done pulses. Optional irq output under TIMER_CTRL_IRQ_EN.
module timer_ctrl #(
  parameter int CW = 16,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] period,
  input  logic [RW-1:0] reps,
  output logic          cnt_en,
  output logic [CW-1:0] cnt_trigger,
  input  logic          cnt_pulse,
  output logic          busy,
  output logic          tick,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] ticks_done
`ifdef TIMER_CTRL_IRQ_EN
  ,
  input  logic          irq_clr,
  output logic          irq
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] trig_n;
  logic [RW-1:0] reps_q, reps_n;
  logic [RW-1:0] ticks_n, ticks_inc;
  logic          tick_n, done_n, err_n;

  assign ticks_inc = (ticks_done == '1) ? ticks_done : ticks_done + RW'(1);

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_n = state;
    trig_n  = cnt_trigger;
    reps_n  = reps_q;
    ticks_n = ticks_done;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (period != '0) begin
              trig_n  = period;
              reps_n  = reps;
              ticks_n = '0;
              state_n = RUN;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_pulse) begin
            tick_n  = 1'b1;
            ticks_n = ticks_inc;
            if (reps_q != '0 && ticks_inc == reps_q) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = RELOAD;
            end
          end
        end
        RELOAD: state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_en      <= 1'b0;
      busy        <= 1'b0;
      tick        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt_trigger <= '0;
      reps_q      <= '0;
      ticks_done  <= '0;
    end else begin
      state       <= state_n;
      cnt_en      <= (state_n == RUN);
      busy        <= (state_n != IDLE);
      tick        <= tick_n;
      done        <= done_n;
      err         <= err_n;
      cnt_trigger <= trig_n;
      reps_q      <= reps_n;
      ticks_done  <= ticks_n;
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  // Sticky interrupt: set coincides with the registered done/err pulse and beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (done_n || err_n) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: attaches a counter model and compares every cycle
// against an arithmetic schedule (ticks land on multiples of period+2 after the start cycle).
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  reps = '0;
  logic        cnt_en;
  logic [15:0] cnt_trigger;
  logic        cnt_pulse;
  logic        busy, tick, done, err;
  logic [7:0]  ticks_done;
  logic        pulse_force = 1'b0;
  logic [15:0] cnt_q = '0;
`ifdef TIMER_CTRL_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        irq;
`endif

  int compared = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // External up counter: clears while disabled, match pulse is combinational.
  always @(posedge clk) cnt_q <= cnt_en ? cnt_q + 16'd1 : 16'd0;
  assign cnt_pulse = pulse_force | (cnt_en && cnt_q == cnt_trigger);

  timer_ctrl #(.CW(16), .RW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period), .reps(reps),
    .cnt_en(cnt_en), .cnt_trigger(cnt_trigger), .cnt_pulse(cnt_pulse), .busy(busy),
    .tick(tick), .done(done), .err(err), .ticks_done(ticks_done)
`ifdef TIMER_CTRL_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    if ({cnt_en, busy, tick, done, err} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags got %b want 00000", {cnt_en, busy, tick, done, err});
    end
    compared++;
    if (ticks_done !== 8'd0 || cnt_trigger !== 16'd0) begin
      fails++; $display("[TB] FAIL reset_values got ticks=%0d trig=%0d want 0/0", ticks_done, cnt_trigger);
    end
    compared++;
    rst = 1'b0;
    pulse_force = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({cnt_en, busy, tick, done, err} !== 5'b0 || ticks_done !== 8'd0) begin
        fails++; $display("[TB] FAIL idle_outputs k=%0d got %b/%0d want 00000/0", k,
                          {cnt_en, busy, tick, done, err}, ticks_done);
      end
      compared++;
    end
    pulse_force = 1'b0;
    @(negedge clk);
  endtask

  // Launches a run at the current negedge and checks every cycle for ncyc cycles.
  // stop_at (if >0) is the cycle whose posedge sees stop together with a counter match.
  task automatic test_run(input int p, input int r, input int ncyc, input int stop_at, input bit poke);
    int per, n, e_ticks, last;
    bit e_tick, e_done, e_busy, e_en;
    per = p + 2;
    last = r * per;
    start = 1'b1; period = 16'(p); reps = 8'(r);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      n = k / per;
      if (r != 0 && n > r) n = r;
      e_ticks = (n > 255) ? 255 : n;
      e_busy  = (r == 0) || (k < last);
      e_tick  = (k % per == 0) && (r == 0 || k <= last);
      e_done  = (r != 0) && (k == last);
      e_en    = e_busy && (k % per != 0);
      if (stop_at > 0 && k >= stop_at) begin
        n = (stop_at - 1) / per;
        e_ticks = (n > 255) ? 255 : n;
        e_busy = 1'b0; e_tick = 1'b0; e_done = 1'b0; e_en = 1'b0;
      end
      if (tick !== e_tick) begin
        fails++; $display("[TB] FAIL tick p=%0d k=%0d got %b want %b", p, k, tick, e_tick);
      end
      compared++;
      if (done !== e_done) begin
        fails++; $display("[TB] FAIL done p=%0d k=%0d got %b want %b", p, k, done, e_done);
      end
      compared++;
      if (busy !== e_busy) begin
        fails++; $display("[TB] FAIL busy p=%0d k=%0d got %b want %b", p, k, busy, e_busy);
      end
      compared++;
      if (cnt_en !== e_en) begin
        fails++; $display("[TB] FAIL cnt_en p=%0d k=%0d got %b want %b", p, k, cnt_en, e_en);
      end
      compared++;
      if (ticks_done !== 8'(e_ticks)) begin
        fails++; $display("[TB] FAIL ticks_done p=%0d k=%0d got %0d want %0d", p, k, ticks_done, e_ticks);
      end
      compared++;
      if (cnt_trigger !== 16'(p) || err !== 1'b0) begin
        fails++; $display("[TB] FAIL trigger_err p=%0d k=%0d got %0d/%b want %0d/0", p, k, cnt_trigger, err, p);
      end
      compared++;
      if (k == 1) begin
        start = 1'b0;
        period = 16'($urandom_range(1, 500));
        reps = 8'($urandom);
      end
      if (poke && k == 2) begin start = 1'b1; period = 16'd9; end
      if (poke && k == 3) start = 1'b0;
      if (stop_at > 0 && k == stop_at - 1) stop = 1'b1;
      if (stop_at > 0 && k == stop_at) stop = 1'b0;
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err(input int held);
    start = 1'b1; period = 16'd0; reps = 8'd3;
    @(negedge clk);
    start = 1'b0;
    if (err !== 1'b1 || busy !== 1'b0 || cnt_en !== 1'b0 || ticks_done !== 8'(held)) begin
      fails++; $display("[TB] FAIL err_pulse got err=%b busy=%b en=%b ticks=%0d want 1/0/0/%0d",
                        err, busy, cnt_en, ticks_done, held);
    end
    compared++;
    @(negedge clk);
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL err_single got err=%b busy=%b want 0/0", err, busy);
    end
    compared++;
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; period = 16'd4; reps = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if ({cnt_en, busy, tick, done} !== 4'b0 || ticks_done !== 8'd0 || cnt_trigger !== 16'd0) begin
      fails++; $display("[TB] FAIL async_reset got %b/%0d/%0d want 0000/0/0",
                        {cnt_en, busy, tick, done}, ticks_done, cnt_trigger);
    end
    compared++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || cnt_en !== 1'b0 || tick !== 1'b0) begin
        fails++; $display("[TB] FAIL post_reset k=%0d got done=%b en=%b tick=%b want 0/0/0", k, done, cnt_en, tick);
      end
      compared++;
    end
  endtask

`ifdef TIMER_CTRL_IRQ_EN
  task automatic test_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    if (irq !== 1'b0) begin
      fails++; $display("[TB] FAIL irq_preclear got %b want 0", irq);
    end
    compared++;
    start = 1'b1; period = 16'd1; reps = 8'd1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (irq !== (k >= 3) || done !== (k == 3)) begin
        fails++; $display("[TB] FAIL irq_run k=%0d got irq=%b done=%b want %b/%b", k, irq, done, k >= 3, k == 3);
      end
      compared++;
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    if (irq !== 1'b0) begin
      fails++; $display("[TB] FAIL irq_clear got %b want 0", irq);
    end
    compared++;
  endtask
`endif

  task automatic test_random();
    int p, r;
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(1, 6);
      r = $urandom_range(1, 4);
      test_run(p, r, r * (p + 2) + 3, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_run(3, 2, 14, 0, 1'b0);
    test_err(2);
    test_run(2, 0, 48, 44, 1'b0);
    test_run(5, 3, 25, 0, 1'b1);
    test_run(1, 0, 805, 801, 1'b0);
    test_random();
    test_reset_midrun();
`ifdef TIMER_CTRL_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Sequencing controller that drives the team's general-purpose up counter and consumes its trigger pulse.
- Loads the trigger value and gates the counter enable.
- Re-arms the counter after each match, emitting periodic single-cycle ticks.
- Stops after a programmed number of ticks, or runs free until told to stop.
- Sits between the register/config logic and the counter; its tick/done outputs feed downstream event logic.

Parameters:
- CW, 16, width of the period / counter trigger value.
- RW, 8, width of the repetition count and tick tally.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  in  1  abort the run; returns to IDLE from any state.
- period  in  CW  counter match value; latched on accepted start.
- reps  in  RW  number of ticks before done; 0 = run until stop; latched on accepted start.
- cnt_en  out  1  enable to counter (counter clears to 0 when low).
- cnt_trigger  out  CW  trigger value to counter.
- cnt_pulse  in  1  counter match pulse (combinational on counter side).
- busy  out  1  high in RUN and RELOAD.
- tick  out  1  single-cycle pulse per accepted match.
- done  out  1  single-cycle pulse when reps ticks are completed.
- err  out  1  single-cycle pulse when start is rejected.
- ticks_done  out  RW  ticks issued in the current/last run; saturates at all-ones.

Behaviour:
- Reset (async): state=IDLE. cnt_en, tick, done, err, busy, cnt_trigger and ticks_done are all 0.
- All outputs are registered.
- States:
  - IDLE: cnt_en=0.
  - RUN: cnt_en=1, waiting for cnt_pulse.
  - RELOAD: one cycle with cnt_en=0 to clear the counter.
- IDLE, start=1, period!=0: latch period into cnt_trigger and reps; clear ticks_done; next state RUN with cnt_en=1.
- IDLE, start=1, period==0: stay IDLE; err=1 for one cycle.
- RUN, cnt_pulse=1: tick=1 next cycle; ticks_done increments (saturating).
  - If reps!=0 and this is tick number reps: done=1 in the same cycle as tick; next state IDLE.
  - Otherwise: next state RELOAD.
- RUN, cnt_pulse=0: stay in RUN.
- cnt_pulse is ignored outside RUN. While idle the counter holds at 0, so a trigger of 0 would otherwise match.
- RELOAD: next state RUN unconditionally.
- Timing:
  - First tick arrives period+1 cycles after the cnt_en rising edge.
  - Subsequent ticks are spaced period+2 cycles apart.
- start while busy is ignored (no err); latched values do not change mid-run.
- stop=1 in any state: next state IDLE with cnt_en=0, no tick, no done. ticks_done is held.
- stop wins over start, and over cnt_pulse in the same cycle.
- reps==0: tick repeats indefinitely, done never asserts, ticks_done saturates at 2^RW-1.
- Reset mid-run: immediate return to IDLE. All outputs drop asynchronously; no done is issued.

Optional Feature:
TIMER_CTRL_IRQ_EN
- Defined: adds input irq_clr (1 bit) and output irq (1 bit).
  - irq is sticky and is set the cycle done or err asserts.
  - irq is cleared by irq_clr=1; set has priority over clear in the same cycle.
  - irq resets to 0.
- Undefined: neither port exists; all other behaviour is unchanged.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, cnt_en stays 0, even with cnt_pulse forced high.
- period=3, reps=2, start pulse at cycle 0, with a bench counter model attached:
  - cnt_en high from cycle 1.
  - tick at cycles 5 and 10; done at cycle 10.
  - busy low from cycle 10; ticks_done=2.
- period=0, start -> err pulse 1 cycle, state stays IDLE, cnt_en=0, ticks_done unchanged.
- period=2, reps=0:
  - ticks every 4 cycles for 40 cycles.
  - stop asserted in the same cycle as a cnt_pulse -> no tick, cnt_en=0 next cycle, done never seen.
- Second start while busy with period=9 -> ignored; tick spacing stays period+2 of the first run; cnt_trigger unchanged.
- With TIMER_CTRL_IRQ_EN: period=1, reps=1 run -> irq sets at done and stays high; irq_clr pulse -> irq=0 next cycle.
